// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT_DONE
  } txq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Power-of-two byte FIFO with synchronous flush; pointers wrap naturally.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [UART_DATA_W-1:0] i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [UART_DATA_W-1:0] o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [ADDR_W:0]        o_level
);

  localparam logic [ADDR_W:0] LP_FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic                   w_push;
  logic                   w_pop;

  assign o_full    = (r_count == LP_FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Flush wins over a same-cycle write; a full queue never accepts, even alongside a pop.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty;

  // Storage write (no reset needed for the data array).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus launch sequencer feeding a UART transmitter.
// Optional sticky overflow flag: define UART_TXQ_OVF_EN to enable.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_busy,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  txq_state_t             r_state;
  txq_state_t             w_state_nxt;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_rd_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (wr_en),
    .i_push_data (wr_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_rd_data   (w_rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level)
  );

  assign full     = w_full;
  assign empty    = w_empty;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and pop decode; every pop leads into LAUNCH.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = GUARD;
      GUARD:  w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = LAUNCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Launch register: the start pulse coincides with LAUNCH; data holds until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= w_rd_data;
    end
  end

`ifdef UART_TXQ_OVF_EN
  logic r_ovf;

  // Sticky overflow: a dropped write outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_ovf <= 1'b0;
    else if (wr_en && w_full && !flush) r_ovf <= 1'b1;
    else if (ovf_clr)                   r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign ovf              = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple registered-busy transmitter model.
module tb_uart_tx_queue;

  localparam int FRAME = 6;
`ifdef UART_TXQ_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       ovf;
  logic       ovf_clr;

  int         n_vec = 0;
  int         n_err = 0;
  int         busy_cnt;
  logic       hold_busy;
  logic [7:0] rx_buf [64];
  int         rx_n = 0;
  int         n_overlap = 0;
  int         n_double = 0;
  logic       prev_start = 1'b0;

  uart_tx_queue #(
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: samples tx_start on the clock, raises busy for FRAME cycles.
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      if (tx_busy) n_overlap++;
      rx_buf[rx_n] = tx_data;
      rx_n++;
      busy_cnt <= FRAME;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (tx_start && prev_start) n_double++;
    prev_start = tx_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the write for exactly one posedge.
  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_start && k < budget);
    check(tag, {31'd0, tx_start}, 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (rx_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_n, target);
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'h00);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_level",    {27'd0, level},    32'd0);
    check("rst_ovf",      {31'd0, ovf},      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte
    base = rx_n;
    push(8'hA5);
    check("single_level1", {27'd0, level},    32'd1);
    check("single_nostart", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("single_start", {31'd0, tx_start}, 32'd1);
    check("single_data",  {24'd0, tx_data},  32'hA5);
    check("single_level0", {27'd0, level},   32'd0);
    @(negedge clk);
    check("single_pulse_end", {31'd0, tx_start}, 32'd0);
    settle();
    check("single_rx_count", rx_n, base + 1);
    check("single_rx_byte", {24'd0, rx_buf[base]}, 32'hA5);

    // Burst to full, then overflow
    base = rx_n;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("burst_full",  {31'd0, full},  32'd1);
    check("burst_level", {27'd0, level}, 32'd16);
    push(8'hFF);
    check("ovf_level", {27'd0, level}, 32'd16);
    check("ovf_flag",  {31'd0, ovf},   {31'd0, EXP_OVF});
    @(negedge clk);
    check("ovf_sticky", {31'd0, ovf}, {31'd0, EXP_OVF});
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
    hold_busy = 1'b0;
    wait_rx("burst_drain", base + 16, 800);
    settle();
    check("burst_rx_count", rx_n, base + 16);
    for (int i = 0; i < 16; i++) check("burst_byte", {24'd0, rx_buf[base + i]}, i);
    check("burst_empty", {31'd0, empty}, 32'd1);

    // Busy held with 3 bytes queued
    base = rx_n;
    hold_busy = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (5) @(negedge clk);
    check("held_level",   {27'd0, level}, 32'd3);
    check("held_nostart", rx_n, base);
    hold_busy = 1'b0;
    @(negedge clk);
    check("held_release_start", {31'd0, tx_start}, 32'd1);
    check("held_release_data",  {24'd0, tx_data},  32'h11);
    check("held_release_level", {27'd0, level},    32'd2);
    wait_rx("held_drain", base + 3, 400);
    settle();
    check("held_rx_count", rx_n, base + 3);
    check("held_b0", {24'd0, rx_buf[base]},     32'h11);
    check("held_b1", {24'd0, rx_buf[base + 1]}, 32'h22);
    check("held_b2", {24'd0, rx_buf[base + 2]}, 32'h33);

    // Flush mid-frame, with a competing write
    base = rx_n;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    push(8'h44);
    check("flush_pre_level", {27'd0, level}, 32'd3);
    check("flush_pre_busy",  {31'd0, tx_busy}, 32'd1);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_level", {27'd0, level}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    settle();
    check("flush_rx_count", rx_n, base + 1);
    check("flush_rx_byte", {24'd0, rx_buf[base]}, 32'h41);

    // Reset during LAUNCH
    push(8'h5A);
    push(8'h6B);
    wait_start("rst_wait_launch", 20);
    base = rx_n;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_empty",    {31'd0, empty},    32'd1);
    check("midrst_level",    {27'd0, level},    32'd0);
    check("midrst_tx_data",  {24'd0, tx_data},  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h3C);
    wait_start("restart_launch", 20);
    check("restart_data", {24'd0, tx_data}, 32'h3C);
    settle();
    check("restart_rx_count", rx_n, base + 1);
    check("restart_rx_byte", {24'd0, rx_buf[base]}, 32'h3C);

    check("no_double_start", n_double, 0);
    check("no_start_while_busy", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
